ether_tx_arbiter: RTL and testbench
===================================

Name: ether_tx_arbiter

Overview:
- Shares the single GMII transmit path (phy_en/phy_er/phy_data at 125 MHz) between two frame sources, e.g. the ARP responder and the UDP sender.
- Each source requests, is granted, then streams one complete frame (preamble..FCS) as an en/data byte stream.
- The arbiter registers the granted stream onto the PHY, enforces the inter-frame gap and alternates service round-robin.
- Sits between the frame generators and the GMII pins.

Parameters:
- IFG_BYTES, 12, minimum number of idle cycles with phy_en low between frames.
- START_TIMEOUT, 16, cycles a granted source has to raise its en before its grant is withdrawn.
- MAX_FRAME, 1530, byte limit per frame, preamble included. Used only with TX_WATCHDOG_EN.

Ports:
- clk_125  in  1  125 MHz GMII TX clock.
- rst  in  1  asynchronous, active-high reset.
- req0  in  1  source 0 requests the medium for one frame.
- gnt0  out  1  source 0 owns the medium.
- en0  in  1  source 0 frame-valid.
- data0  in  8  source 0 frame byte.
- req1  in  1  source 1 request.
- gnt1  out  1  source 1 grant.
- en1  in  1  source 1 frame-valid.
- data1  in  8  source 1 frame byte.
- phy_en  out  1  GMII TX_EN.
- phy_er  out  1  GMII TX_ER.
- phy_data  out  8  GMII TXD.
- busy  out  1  high in any state except IDLE.
- abort  out  1  one-cycle pulse when a grant or frame is terminated abnormally.

Behaviour:
- Reset (asynchronous, immediate): all outputs 0, state IDLE, last_served=1 (source 0 wins first). Reset mid-frame truncates phy_en that same edge.
- States: IDLE, GRANT, ACTIVE, IFG. All outputs are registered.
- IDLE:
  - Only req0 high: grant 0. Only req1 high: grant 1.
  - Both high in the same cycle: grant the source that is not last_served.
  - The gnt for the selected source rises on the next clock edge. Go to GRANT and clear the timer.
- GRANT:
  - gnt held. The non-granted source's en/data are ignored in every state.
  - Granted en=1: go to ACTIVE. This byte appears on phy_data/phy_en one cycle later (fixed 1-cycle latency).
  - Granted req drops before en: gnt=0, go to IDLE, no abort.
  - Timer reaches START_TIMEOUT with no en: gnt=0, abort pulse, go to IDLE. last_served is updated to this source.
- ACTIVE:
  - phy_en<=granted en, phy_data<=granted data every cycle. phy_er=0.
  - Granted en falls: phy_en falls on the next edge, gnt drops on that same edge, last_served<=granted source. Load the IFG counter with IFG_BYTES-1 and go to IFG.
  - req is not examined in ACTIVE. A source that drops req mid-frame still completes on en.
- IFG:
  - phy_en=0, phy_data=0. Counter decrements each cycle.
  - At 0, go to IDLE.
  - Requests arriving during IFG are held and are not lost; they are arbitrated in IDLE.
  - Guarantee: the rising edge of the next phy_en is at least IFG_BYTES+2 cycles after the falling edge of phy_en (IFG plus IDLE and GRANT cycles).
- Counters:
  - Timer is 5 bits.
  - Byte counter is 11 bits and saturates, no wrap.
  - IFG counter is 4 bits. IFG_BYTES must be >=1 and <=16.

Optional Feature:
- Macro TX_WATCHDOG_EN.
- Defined:
  - ACTIVE counts bytes with phy_en high.
  - If the count reaches MAX_FRAME while the granted en is still high, the next cycle drives phy_er=1, phy_en=1 and phy_data=0 for exactly one cycle.
  - After that cycle: phy_en=0, gnt=0, abort pulse, go to IFG. The source's remaining bytes are discarded until its en drops.
  - The source must not re-request until its en is low. The arbiter masks its req while its en is high.
- Undefined: no byte counter. phy_er is tied to 0. Frames of any length pass through.

Test Plan:
- req0 pulses high, source 0 sends a 72-byte frame -> gnt0 rises 1 cycle after req0. phy_data mirrors data0 delayed by 1 cycle for 72 cycles. gnt0 falls with phy_en. busy is low 12 cycles after phy_en falls.
- req0 and req1 both high from reset -> source 0 served first, then source 1. phy_en stays low ≥14 cycles between the frames. en1/data1 activity during frame 0 never appears on the PHY.
- req1 raised during the IFG of a source-0 frame -> no grant until IFG expires. gnt1 rises on the cycle after IDLE is entered.
- req0 high, en0 never asserted -> gnt0 drops after 16 cycles, abort pulses once, a pending req1 is granted next.
- assert rst while phy_en=1 mid-frame -> phy_en, gnt0 and busy are 0 asynchronously. After release, req1 alone is granted normally.
- With TX_WATCHDOG_EN and MAX_FRAME=100, source sends 150 bytes -> 100 bytes forwarded, then one cycle of phy_er=1, then phy_en=0. abort pulses. Source re-requests after en drops and is granted only after 12 idle cycles.

Source files
------------

// File: rtl/ether_tx_arbiter.sv
// Two-source GMII transmit arbiter: round-robin grant, registered byte path, inter-frame gap.
// Define TX_WATCHDOG_EN to cut off frames longer than MAX_FRAME bytes with a one-cycle TX_ER.
module ether_tx_arbiter #(
    parameter int IFG_BYTES     = 12,
    parameter int START_TIMEOUT = 16
`ifdef TX_WATCHDOG_EN
    ,
    parameter int MAX_FRAME     = 1530
`endif
) (
    input  logic       clk_125,
    input  logic       rst,
    input  logic       req0,
    output logic       gnt0,
    input  logic       en0,
    input  logic [7:0] data0,
    input  logic       req1,
    output logic       gnt1,
    input  logic       en1,
    input  logic [7:0] data1,
    output logic       phy_en,
    output logic       phy_er,
    output logic [7:0] phy_data,
    output logic       busy,
    output logic       abort
);

    // state    | meaning
    // S_IDLE   | medium free, arbitrate pending requests
    // S_GRANT  | grant issued, waiting for the source's first en byte
    // S_ACTIVE | forwarding the granted source's byte stream to the PHY
    // S_IFG    | inter-frame gap, phy_en held low
    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_GRANT  = 2'd1,
        S_ACTIVE = 2'd2,
        S_IFG    = 2'd3
    } state_t;

    localparam logic [3:0] IFG_LOAD = 4'(IFG_BYTES - 1);
    localparam logic [4:0] TMO_LAST = 5'(START_TIMEOUT - 1);

    state_t     state, state_nxt;
    logic       sel, sel_nxt;
    logic       last_served, last_served_nxt;
    logic [4:0] timer, timer_nxt;
    logic [3:0] ifg_cnt, ifg_cnt_nxt;
    logic       phy_en_nxt;
    logic [7:0] phy_data_nxt;
    logic       abort_nxt;
    logic       end_frame;
    logic       req_m0, req_m1;
    logic       g_req, g_en;
    logic [7:0] g_data;

    assign g_req  = sel ? req1  : req0;
    assign g_en   = sel ? en1   : en0;
    assign g_data = sel ? data1 : data0;

`ifdef TX_WATCHDOG_EN
    localparam logic [10:0] MAX_CNT = 11'(MAX_FRAME);

    logic [10:0] byte_cnt, byte_cnt_nxt;
    logic        wd_err, wd_err_nxt;
    logic        phy_er_nxt;

    // A cut-off source keeps streaming until its en drops; hide its request until then.
    assign req_m0 = req0 & ~en0;
    assign req_m1 = req1 & ~en1;
`else
    assign req_m0 = req0;
    assign req_m1 = req1;
    assign phy_er = 1'b0;
`endif

    always_comb begin
        state_nxt       = state;
        sel_nxt         = sel;
        last_served_nxt = last_served;
        timer_nxt       = timer;
        ifg_cnt_nxt     = ifg_cnt;
        phy_en_nxt      = 1'b0;
        phy_data_nxt    = 8'h00;
        abort_nxt       = 1'b0;
        end_frame       = 1'b0;
`ifdef TX_WATCHDOG_EN
        byte_cnt_nxt    = byte_cnt;
        wd_err_nxt      = 1'b0;
        phy_er_nxt      = 1'b0;
`endif

        case (state)
            S_IDLE: begin
                // On a tie, last_served is 1 after reset so source 0 wins first.
                if (req_m0 && (!req_m1 || last_served)) begin
                    sel_nxt   = 1'b0;
                    timer_nxt = 5'd0;
                    state_nxt = S_GRANT;
                end else if (req_m1) begin
                    sel_nxt   = 1'b1;
                    timer_nxt = 5'd0;
                    state_nxt = S_GRANT;
                end
            end

            S_GRANT: begin
                if (g_en) begin
                    phy_en_nxt   = 1'b1;
                    phy_data_nxt = g_data;
                    state_nxt    = S_ACTIVE;
`ifdef TX_WATCHDOG_EN
                    byte_cnt_nxt = 11'd1;
`endif
                end else if (!g_req) begin
                    state_nxt = S_IDLE;
                end else if (timer == TMO_LAST) begin
                    abort_nxt       = 1'b1;
                    last_served_nxt = sel;
                    state_nxt       = S_IDLE;
                end else begin
                    timer_nxt = timer + 5'd1;
                end
            end

            S_ACTIVE: begin
`ifdef TX_WATCHDOG_EN
                if (wd_err) begin
                    end_frame = 1'b1;
                    abort_nxt = 1'b1;
                end else if (!g_en) begin
                    end_frame = 1'b1;
                end else if (byte_cnt >= MAX_CNT) begin
                    phy_en_nxt = 1'b1;
                    phy_er_nxt = 1'b1;
                    wd_err_nxt = 1'b1;
                end else begin
                    phy_en_nxt   = 1'b1;
                    phy_data_nxt = g_data;
                    if (byte_cnt != 11'h7ff) begin
                        byte_cnt_nxt = byte_cnt + 11'd1;
                    end
                end
`else
                if (!g_en) begin
                    end_frame = 1'b1;
                end else begin
                    phy_en_nxt   = 1'b1;
                    phy_data_nxt = g_data;
                end
`endif
                if (end_frame) begin
                    last_served_nxt = sel;
                    ifg_cnt_nxt     = IFG_LOAD;
                    state_nxt       = S_IFG;
                end
            end

            S_IFG: begin
                if (ifg_cnt == 4'd0) begin
                    state_nxt = S_IDLE;
                end else begin
                    ifg_cnt_nxt = ifg_cnt - 4'd1;
                end
            end

            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_125 or posedge rst) begin
        if (rst) begin
            state       <= S_IDLE;
            sel         <= 1'b0;
            last_served <= 1'b1;
            timer       <= 5'd0;
            ifg_cnt     <= 4'd0;
            gnt0        <= 1'b0;
            gnt1        <= 1'b0;
            phy_en      <= 1'b0;
            phy_data    <= 8'h00;
            busy        <= 1'b0;
            abort       <= 1'b0;
        end else begin
            state       <= state_nxt;
            sel         <= sel_nxt;
            last_served <= last_served_nxt;
            timer       <= timer_nxt;
            ifg_cnt     <= ifg_cnt_nxt;
            // Grant follows the next state so it drops on the same edge as phy_en.
            gnt0        <= ((state_nxt == S_GRANT) || (state_nxt == S_ACTIVE)) && !sel_nxt;
            gnt1        <= ((state_nxt == S_GRANT) || (state_nxt == S_ACTIVE)) && sel_nxt;
            phy_en      <= phy_en_nxt;
            phy_data    <= phy_data_nxt;
            busy        <= (state_nxt != S_IDLE);
            abort       <= abort_nxt;
        end
    end

`ifdef TX_WATCHDOG_EN
    always_ff @(posedge clk_125 or posedge rst) begin
        if (rst) begin
            byte_cnt <= 11'd0;
            wd_err   <= 1'b0;
            phy_er   <= 1'b0;
        end else begin
            byte_cnt <= byte_cnt_nxt;
            wd_err   <= wd_err_nxt;
            phy_er   <= phy_er_nxt;
        end
    end
`endif

endmodule

// File: tb/tb_ether_tx_arbiter.sv
// Directed bench for ether_tx_arbiter: a cycle table for grant/forward/IFG plus hand-written
// sequences for long frames, round-robin, start timeout, async reset and the optional watchdog.
module tb_ether_tx_arbiter;

    localparam int IFG = 12;

    logic       clk_125 = 1'b0;
    logic       rst;
    logic       req0, en0, req1, en1;
    logic [7:0] data0, data1;
    logic       gnt0, gnt1, phy_en, phy_er, busy, abort;
    logic [7:0] phy_data;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int g0_cnt, ab_cnt, ab_at, g1_at, fall_cyc, wd_fall;
    logic [7:0] b;

    typedef struct {
        logic       req0, en0;
        logic [7:0] data0;
        logic       req1, en1;
        logic [7:0] data1;
        logic       gnt0, gnt1, phy_en, phy_er, busy, abort;
        logic [7:0] phy_data;
    } vec_t;

    vec_t vecs[$];

    ether_tx_arbiter #(
        .IFG_BYTES(IFG),
        .START_TIMEOUT(16)
`ifdef TX_WATCHDOG_EN
        ,
        .MAX_FRAME(100)
`endif
    ) dut (
        .clk_125 (clk_125),
        .rst     (rst),
        .req0    (req0),
        .gnt0    (gnt0),
        .en0     (en0),
        .data0   (data0),
        .req1    (req1),
        .gnt1    (gnt1),
        .en1     (en1),
        .data1   (data1),
        .phy_en  (phy_en),
        .phy_er  (phy_er),
        .phy_data(phy_data),
        .busy    (busy),
        .abort   (abort)
    );

    always #4 clk_125 = ~clk_125;

    task automatic tick();
        @(posedge clk_125);
        #1;
        cyc++;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic drive(input logic r0, input logic e0, input logic [7:0] d0,
                         input logic r1, input logic e1, input logic [7:0] d1);
        req0  = r0;
        en0   = e0;
        data0 = d0;
        req1  = r1;
        en1   = e1;
        data1 = d1;
    endtask

    function automatic vec_t mk(input logic r0, input logic e0, input logic [7:0] d0,
                                input logic r1, input logic e1, input logic [7:0] d1,
                                input logic g0, input logic g1, input logic pe,
                                input logic [7:0] pd, input logic bz, input logic ab);
        vec_t v;
        v.req0 = r0;  v.en0 = e0;  v.data0 = d0;
        v.req1 = r1;  v.en1 = e1;  v.data1 = d1;
        v.gnt0 = g0;  v.gnt1 = g1; v.phy_en = pe; v.phy_er = 1'b0;
        v.phy_data = pd; v.busy = bz; v.abort = ab;
        return v;
    endfunction

    task automatic wait_idle(input string name);
        for (int k = 0; k < 64 && busy !== 1'b0; k++) tick();
        check({name, "_wait_idle"}, busy, 0);
    endtask

    initial begin
        rst = 1'b1;
        drive(0, 0, 8'h00, 0, 0, 8'h00);

        // Cycle table: each row's inputs are applied, one edge passes, outputs are compared.
        //                  r0 e0 d0     r1 e1 d1     g0 g1 pe pd     busy abort
        vecs.push_back(mk(0, 0, 8'h00, 0, 0, 8'h00, 0, 0, 0, 8'h00, 0, 0));
        vecs.push_back(mk(1, 0, 8'h00, 0, 0, 8'h00, 1, 0, 0, 8'h00, 1, 0));
        vecs.push_back(mk(1, 1, 8'h55, 0, 1, 8'hAA, 1, 0, 1, 8'h55, 1, 0));
        vecs.push_back(mk(0, 1, 8'h5A, 0, 1, 8'hBB, 1, 0, 1, 8'h5A, 1, 0));
        vecs.push_back(mk(0, 1, 8'hD5, 0, 0, 8'h00, 1, 0, 1, 8'hD5, 1, 0));
        vecs.push_back(mk(0, 0, 8'h00, 0, 0, 8'h00, 0, 0, 0, 8'h00, 1, 0));
        for (int i = 0; i < 2; i++)
            vecs.push_back(mk(0, 0, 8'h00, 0, 0, 8'h00, 0, 0, 0, 8'h00, 1, 0));
        for (int i = 0; i < 9; i++)
            vecs.push_back(mk(0, 0, 8'h00, 1, 0, 8'h00, 0, 0, 0, 8'h00, 1, 0));
        vecs.push_back(mk(0, 0, 8'h00, 1, 0, 8'h00, 0, 0, 0, 8'h00, 0, 0));
        vecs.push_back(mk(0, 0, 8'h00, 1, 0, 8'h00, 0, 1, 0, 8'h00, 1, 0));
        vecs.push_back(mk(0, 1, 8'h99, 1, 1, 8'h11, 0, 1, 1, 8'h11, 1, 0));
        vecs.push_back(mk(0, 0, 8'h00, 0, 0, 8'h00, 0, 0, 0, 8'h00, 1, 0));

        #10;
        check("rst_gnt0", gnt0, 0);
        check("rst_gnt1", gnt1, 0);
        check("rst_phy_en", phy_en, 0);
        check("rst_phy_er", phy_er, 0);
        check("rst_phy_data", phy_data, 0);
        check("rst_busy", busy, 0);
        check("rst_abort", abort, 0);
        @(posedge clk_125);
        #1;
        rst = 1'b0;

        foreach (vecs[i]) begin
            drive(vecs[i].req0, vecs[i].en0, vecs[i].data0, vecs[i].req1, vecs[i].en1, vecs[i].data1);
            tick();
            check($sformatf("vec%0d_gnt0", i), gnt0, vecs[i].gnt0);
            check($sformatf("vec%0d_gnt1", i), gnt1, vecs[i].gnt1);
            check($sformatf("vec%0d_phy_en", i), phy_en, vecs[i].phy_en);
            check($sformatf("vec%0d_phy_er", i), phy_er, vecs[i].phy_er);
            check($sformatf("vec%0d_phy_data", i), phy_data, vecs[i].phy_data);
            check($sformatf("vec%0d_busy", i), busy, vecs[i].busy);
            check($sformatf("vec%0d_abort", i), abort, vecs[i].abort);
        end

        // 72-byte frame from source 0 after a one-cycle request pulse.
        wait_idle("s1");
        drive(1, 0, 8'h00, 0, 0, 8'h00);
        tick();
        check("s1_gnt0_rise", gnt0, 1);
        check("s1_phy_en_pre", phy_en, 0);
        for (int i = 0; i < 72; i++) begin
            b = 8'(i * 7 + 3);
            drive(0, 1, b, 0, 0, 8'h00);
            tick();
            check("s1_phy_en", phy_en, 1);
            check("s1_phy_data", phy_data, b);
            check("s1_gnt0", gnt0, 1);
        end
        drive(0, 0, 8'h00, 0, 0, 8'h00);
        tick();
        check("s1_phy_en_fall", phy_en, 0);
        check("s1_gnt0_fall", gnt0, 0);
        for (int i = 1; i <= IFG; i++) begin
            tick();
            check($sformatf("s1_busy_%0d", i), busy, (i < IFG));
        end

        // Both requesting out of reset: source 0 first, then source 1 after the gap.
        rst = 1'b1;
        drive(1, 0, 8'h00, 1, 0, 8'h00);
        tick();
        rst = 1'b0;
        tick();
        check("s2_gnt0_first", gnt0, 1);
        check("s2_gnt1_wait", gnt1, 0);
        for (int i = 0; i < 4; i++) begin
            drive(0, 1, 8'(8'h40 + i), 1, 1, 8'hEE);
            tick();
            check("s2_phy_data_src0", phy_data, 8'(8'h40 + i));
            check("s2_gnt1_low", gnt1, 0);
        end
        drive(0, 0, 8'h00, 1, 0, 8'h00);
        tick();
        check("s2_phy_en_fall", phy_en, 0);
        fall_cyc = cyc;
        for (int k = 0; k < 40 && gnt1 !== 1'b1; k++) tick();
        check("s2_gnt1_second", gnt1, 1);
        drive(0, 0, 8'h00, 1, 1, 8'h77);
        tick();
        check("s2_phy_en_rise", phy_en, 1);
        check("s2_phy_data_src1", phy_data, 8'h77);
        check("s2_gap_ge_ifg_plus_2", (cyc - fall_cyc) >= (IFG + 2), 1);
        drive(0, 0, 8'h00, 0, 0, 8'h00);
        tick();
        check("s2_end", phy_en, 0);

        // Source 0 granted but never starts: timeout, one abort, pending source 1 next.
        wait_idle("s3");
        drive(1, 0, 8'h00, 1, 0, 8'h00);
        g0_cnt = 0;
        ab_cnt = 0;
        ab_at  = -1;
        g1_at  = -1;
        for (int k = 0; k < 40; k++) begin
            tick();
            if (gnt0) g0_cnt++;
            if (abort) begin
                ab_cnt++;
                ab_at = k;
            end
            if (gnt1) begin
                g1_at = k;
                break;
            end
        end
        check("s3_gnt0_cycles", g0_cnt, 16);
        check("s3_abort_count", ab_cnt, 1);
        check("s3_abort_at", ab_at, 16);
        check("s3_gnt1_at", g1_at, 17);
        drive(0, 0, 8'h00, 0, 0, 8'h00);
        tick();
        check("s3_req_drop_gnt1", gnt1, 0);
        check("s3_req_drop_no_abort", abort, 0);
        check("s3_req_drop_idle", busy, 0);

        // Asynchronous reset in the middle of a frame.
        drive(1, 0, 8'h00, 0, 0, 8'h00);
        tick();
        check("s4_gnt0", gnt0, 1);
        for (int i = 0; i < 3; i++) begin
            drive(0, 1, 8'(8'hC0 + i), 0, 0, 8'h00);
            tick();
        end
        check("s4_phy_en_mid", phy_en, 1);
        #2;
        rst = 1'b1;
        #1;
        check("s4_rst_phy_en", phy_en, 0);
        check("s4_rst_gnt0", gnt0, 0);
        check("s4_rst_busy", busy, 0);
        check("s4_rst_phy_data", phy_data, 0);
        drive(0, 0, 8'h00, 0, 0, 8'h00);
        tick();
        rst = 1'b0;
        drive(0, 0, 8'h00, 1, 0, 8'h00);
        tick();
        check("s4_gnt1", gnt1, 1);
        check("s4_gnt0_low", gnt0, 0);
        drive(0, 0, 8'h00, 0, 1, 8'h3E);
        tick();
        check("s4_phy_en", phy_en, 1);
        check("s4_phy_data", phy_data, 8'h3E);
        drive(0, 0, 8'h00, 0, 0, 8'h00);
        tick();
        check("s4_phy_en_fall", phy_en, 0);
        check("s4_gnt1_fall", gnt1, 0);

`ifdef TX_WATCHDOG_EN
        // Over-length frame: 100 bytes pass, one TX_ER cycle, then the source is cut off.
        wait_idle("wd");
        drive(1, 0, 8'h00, 0, 0, 8'h00);
        tick();
        check("wd_gnt0", gnt0, 1);
        ab_cnt  = 0;
        wd_fall = 0;
        for (int i = 0; i < 150; i++) begin
            drive(i >= 120, 1, 8'(i), 0, 0, 8'h00);
            tick();
            if (abort) ab_cnt++;
            if (i < 100) begin
                check("wd_fwd_phy_en", phy_en, 1);
                check("wd_fwd_phy_data", phy_data, 8'(i));
                check("wd_fwd_phy_er", phy_er, 0);
            end else if (i == 100) begin
                check("wd_err_phy_en", phy_en, 1);
                check("wd_err_phy_er", phy_er, 1);
                check("wd_err_phy_data", phy_data, 0);
            end else begin
                check("wd_cut_phy_en", phy_en, 0);
                check("wd_cut_phy_er", phy_er, 0);
                check("wd_cut_gnt0", gnt0, 0);
                if (i == 101) wd_fall = cyc;
            end
        end
        check("wd_abort_count", ab_cnt, 1);
        drive(1, 0, 8'h00, 0, 0, 8'h00);
        tick();
        check("wd_regrant", gnt0, 1);
        check("wd_regrant_gap", (cyc - wd_fall) >= IFG, 1);
        drive(0, 0, 8'h00, 0, 0, 8'h00);
        tick();
        check("wd_release", gnt0, 0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
